// File: rtl/frac_period_sched.sv
// -----------------------------------------------------------------------------
// frac_period_sched
//
// Paces a run of num_ops operations so that, on average, one issue credit is
// earned every PERIOD clock cycles, where PERIOD may be fractional. A fixed-
// point accumulator gains ONE per active cycle and yields a credit ("tick")
// each time it reaches PERIOD_FX. Credits are spent by the valid/ready
// handshake towards the datapath. Credits saturate at MAX_CREDIT; while
// saturated the accumulator stalls, so no ticks are lost, and the sticky
// overrun flag records that the datapath fell behind.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   single-cycle run request (accepted in IDLE only)
//   num_ops      in   ops in the run, sampled when start is accepted
//   abort        in   terminate the current run (RUN only), no done pulse
//   issue_valid  out  an op is offered to the datapath
//   issue_ready  in   datapath accepts the offered op
//   busy         out  high while in RUN
//   done         out  one-cycle pulse after the last op is handed off
//   issued_cnt   out  ops handed off in the current or last run
//   overrun      out  sticky: credit reached MAX_CREDIT during this run
// -----------------------------------------------------------------------------
module frac_period_sched #(
    parameter real PERIOD     = 2.5,
    parameter int  FRAC_BITS  = 8,
    parameter int  ACC_W      = 16,
    parameter int  CNT_W      = 16,
    parameter int  MAX_CREDIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    input  logic             abort,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] issued_cnt,
    output logic             overrun
);

    // Period in accumulator units, rounded to nearest at elaboration.
    localparam int               PERIOD_FX_INT = $rtoi(PERIOD * real'(2 ** FRAC_BITS) + 0.5);
    localparam logic [ACC_W-1:0] PERIOD_FX     = ACC_W'(PERIOD_FX_INT);
    localparam logic [ACC_W-1:0] ONE           = ACC_W'(2 ** FRAC_BITS);
    localparam int               CR_W          = $clog2(MAX_CREDIT + 1);
    localparam logic [CR_W-1:0]  CREDIT_MAX    = CR_W'(MAX_CREDIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic [CR_W-1:0]  credit_q,   credit_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0] issued_q,   issued_d;
    logic [CNT_W-1:0] num_ops_q,  num_ops_d;
    logic             overrun_q,  overrun_d;

    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] issued_inc;
    logic             tick_en;
    logic             tick;
    logic             hs;

    // Outputs come from registered state only; issue_ready never feeds back
    // into issue_valid.
    assign issue_valid = (state_q == RUN) && (credit_q != '0);
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign issued_cnt  = issued_q;
    assign overrun     = overrun_q;

    // The accumulator only advances while more ticks are owed and there is
    // room for another credit; otherwise it holds its fractional phase.
    always_comb begin
        acc_sum    = acc_q + ONE;
        issued_inc = issued_q + CNT_W'(1);
        tick_en    = (state_q == RUN) && (tick_cnt_q < num_ops_q) && (credit_q < CREDIT_MAX);
        tick       = tick_en && (acc_sum >= PERIOD_FX);
        hs         = issue_valid && issue_ready;
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        credit_d   = credit_q;
        tick_cnt_d = tick_cnt_q;
        issued_d   = issued_q;
        num_ops_d  = num_ops_q;
        overrun_d  = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_ops_d  = num_ops;
                    acc_d      = '0;
                    credit_d   = '0;
                    tick_cnt_d = '0;
                    issued_d   = '0;
                    overrun_d  = 1'b0;
                    state_d    = (num_ops == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                if (abort) begin
                    // Abort wins over any tick or handshake this cycle;
                    // issued_cnt is kept so software can see how far it got.
                    state_d  = IDLE;
                    credit_d = '0;
                    acc_d    = '0;
                end else begin
                    if (tick_en) begin
                        acc_d = tick ? (acc_sum - PERIOD_FX) : acc_sum;
                    end
                    if (tick) begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                    if (credit_q == CREDIT_MAX) begin
                        overrun_d = 1'b1;
                    end
                    // A tick and a handshake in the same cycle cancel out.
                    unique case ({tick, hs})
                        2'b10:   credit_d = credit_q + CR_W'(1);
                        2'b01:   credit_d = credit_q - CR_W'(1);
                        default: credit_d = credit_q;
                    endcase
                    if (hs) begin
                        issued_d = issued_inc;
                        if (issued_inc == num_ops_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            credit_q   <= '0;
            tick_cnt_q <= '0;
            issued_q   <= '0;
            num_ops_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            credit_q   <= credit_d;
            tick_cnt_q <= tick_cnt_d;
            issued_q   <= issued_d;
            num_ops_q  <= num_ops_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_frac_period_sched.sv
// -----------------------------------------------------------------------------
// tb_frac_period_sched
//
// Three schedulers share one stimulus stream:
//   inst0: PERIOD=2.5, MAX_CREDIT=4
//   inst1: PERIOD=1.0, MAX_CREDIT=4
//   inst2: PERIOD=2.5, MAX_CREDIT=2
// A reference model predicts each one's outputs every cycle. It tracks the
// number of active (accumulating) cycles n and places ticks at the points
// where floor(n*ONE/PERIOD_FX) steps up. Directed windows additionally check
// exact issue/done cycle positions.
// -----------------------------------------------------------------------------
module tb_frac_period_sched;

  localparam int N     = 3;
  localparam int CNT_W = 16;
  localparam int ONE   = 256;

  // PERIOD*256: 2.5 -> 640, 1.0 -> 256
  int pfx [N] = '{640, 256, 640};
  int mcr [N] = '{4, 4, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start;
  logic             abort;
  logic             issue_ready;
  logic [CNT_W-1:0] num_ops;

  logic [N-1:0]            iv, bz, dn, ov;
  logic [N-1:0][CNT_W-1:0] ic;

  frac_period_sched #(.PERIOD(2.5)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops), .abort(abort),
    .issue_valid(iv[0]), .issue_ready(issue_ready), .busy(bz[0]), .done(dn[0]),
    .issued_cnt(ic[0]), .overrun(ov[0])
  );

  frac_period_sched #(.PERIOD(1.0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops), .abort(abort),
    .issue_valid(iv[1]), .issue_ready(issue_ready), .busy(bz[1]), .done(dn[1]),
    .issued_cnt(ic[1]), .overrun(ov[1])
  );

  frac_period_sched #(.PERIOD(2.5), .MAX_CREDIT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops), .abort(abort),
    .issue_valid(iv[2]), .issue_ready(issue_ready), .busy(bz[2]), .done(dn[2]),
    .issued_cnt(ic[2]), .overrun(ov[2])
  );

  int vectors    = 0;
  int miscompares = 0;

  // Model state: m_st 0=idle 1=run 2=done
  int m_st [N], m_n [N], m_tk [N], m_cr [N], m_iss [N], m_nops [N], m_ovr [N];

  logic [31:0] vmask [N], dmask [N], bmask [N];
  int          dcount [N];

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s inst%0d observed=%0d expected=%0d", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_n[i] = 0; m_tk[i] = 0; m_cr[i] = 0;
      m_iss[i] = 0; m_nops[i] = 0; m_ovr[i] = 0;
    end
  endtask

  task automatic model_update(input int i);
    int hs, tk, act;
    hs = (m_st[i] == 1 && m_cr[i] != 0 && issue_ready) ? 1 : 0;
    case (m_st[i])
      0: begin
        if (start) begin
          m_nops[i] = int'(num_ops);
          m_n[i] = 0; m_tk[i] = 0; m_cr[i] = 0; m_iss[i] = 0; m_ovr[i] = 0;
          m_st[i] = (num_ops == 0) ? 2 : 1;
        end
      end
      1: begin
        if (abort) begin
          m_st[i] = 0; m_cr[i] = 0; m_n[i] = 0; m_tk[i] = 0;
        end else begin
          act = (m_tk[i] < m_nops[i] && m_cr[i] < mcr[i]) ? 1 : 0;
          tk  = (act == 1 && ((m_n[i] + 1) * ONE) / pfx[i] > m_tk[i]) ? 1 : 0;
          if (m_cr[i] == mcr[i]) m_ovr[i] = 1;
          m_n[i]  += act;
          m_tk[i] += tk;
          m_cr[i] += tk - hs;
          if (hs == 1) begin
            m_iss[i]++;
            if (m_iss[i] == m_nops[i]) m_st[i] = 2;
          end
        end
      end
      default: m_st[i] = 0;
    endcase
  endtask

  // Called at a falling edge with inputs already driven: check the current
  // cycle, advance the model across the coming rising edge, move on.
  task automatic step();
    for (int i = 0; i < N; i++) begin
      chk("issue_valid", i, 32'(iv[i]), 32'(m_st[i] == 1 && m_cr[i] != 0));
      chk("busy",        i, 32'(bz[i]), 32'(m_st[i] == 1));
      chk("done",        i, 32'(dn[i]), 32'(m_st[i] == 2));
      chk("issued_cnt",  i, 32'(ic[i]), 32'(m_iss[i]));
      chk("overrun",     i, 32'(ov[i]), 32'(m_ovr[i]));
    end
    for (int i = 0; i < N; i++) model_update(i);
    @(negedge clk);
  endtask

  task automatic record(input int c);
    for (int i = 0; i < N; i++) begin
      if (iv[i]) vmask[i][c] = 1'b1;
      if (dn[i]) begin dmask[i][c] = 1'b1; dcount[i]++; end
      if (bz[i]) bmask[i][c] = 1'b1;
    end
  endtask

  task automatic clear_masks();
    for (int i = 0; i < N; i++) begin
      vmask[i] = '0; dmask[i] = '0; bmask[i] = '0; dcount[i] = 0;
    end
  endtask

  // Start pulse at cycle 0, ready held high, abort optionally at one cycle.
  task automatic run_window(input int nops, input int ncyc, input int abort_at);
    clear_masks();
    for (int c = 0; c < ncyc; c++) begin
      start       = (c == 0);
      num_ops     = CNT_W'(nops);
      issue_ready = 1'b1;
      abort       = (c == abort_at);
      if (c < 32) record(c);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; issue_ready = 1'b0; num_ops = '0;
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();

    // Nominal 4-op run with ready held high.
    run_window(4, 14, -1);
    chk("v_mask_4ops", 0, vmask[0], 32'h0000_0A50);
    chk("d_mask_4ops", 0, dmask[0], 32'h0000_1000);
    chk("v_mask_4ops", 1, vmask[1], 32'h0000_003C);
    chk("d_mask_4ops", 1, dmask[1], 32'h0000_0040);
    chk("v_mask_4ops", 2, vmask[2], 32'h0000_0A50);
    chk("issued_end",  0, 32'(ic[0]), 32'd4);

    // 3-op run: PERIOD=1.0 issues on three consecutive cycles.
    run_window(3, 14, -1);
    chk("v_mask_3ops", 1, vmask[1], 32'h0000_001C);
    chk("d_mask_3ops", 1, dmask[1], 32'h0000_0020);
    chk("overrun_3ops", 1, 32'(ov[1]), 32'd0);
    chk("v_mask_3ops", 0, vmask[0], 32'h0000_0250);
    chk("d_mask_3ops", 0, dmask[0], 32'h0000_0400);

    // Zero-op run goes straight to a done pulse.
    run_window(0, 6, -1);
    for (int i = 0; i < N; i++) begin
      chk("d_mask_0ops", i, dmask[i], 32'h0000_0002);
      chk("v_mask_0ops", i, vmask[i], 32'h0);
      chk("b_mask_0ops", i, bmask[i], 32'h0);
    end

    // Abort after two handshakes of a 5-op run (inst0: handshakes at 4 and 6).
    run_window(5, 14, 7);
    chk("abort_issued", 0, 32'(ic[0]), 32'd2);
    chk("abort_busy_c8", 0, 32'(bmask[0][8]), 32'd0);
    chk("abort_valid", 0, vmask[0] & 32'hFFFF_FF00, 32'h0);
    chk("abort_nodone", 0, dmask[0], 32'h0);
    run_window(4, 14, -1);
    chk("v_after_abort", 0, vmask[0], 32'h0000_0A50);
    chk("d_after_abort", 0, dmask[0], 32'h0000_1000);

    // Datapath stalled for 20 cycles: credit saturates and overrun sticks.
    clear_masks();
    for (int c = 0; c < 60; c++) begin
      start       = (c == 0);
      num_ops     = CNT_W'(6);
      issue_ready = (c >= 21);
      record(0);
      step();
    end
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("sat_issued",  i, 32'(ic[i]), 32'd6);
      chk("sat_overrun", i, 32'(ov[i]), 32'd1);
      chk("sat_dcount",  i, 32'(dcount[i]), 32'd1);
    end

    // Asynchronous reset mid-run while inst0 holds two credits.
    for (int c = 0; c < 7; c++) begin
      start       = (c == 0);
      num_ops     = CNT_W'(6);
      issue_ready = 1'b0;
      step();
    end
    start = 1'b0;
    chk("pre_reset_valid", 0, 32'(iv[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_valid",   i, 32'(iv[i]), 32'd0);
      chk("rst_busy",    i, 32'(bz[i]), 32'd0);
      chk("rst_done",    i, 32'(dn[i]), 32'd0);
      chk("rst_issued",  i, 32'(ic[i]), 32'd0);
      chk("rst_overrun", i, 32'(ov[i]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_window(4, 14, -1);
    chk("v_after_rst", 0, vmask[0], 32'h0000_0A50);
    chk("d_after_rst", 0, dmask[0], 32'h0000_1000);

    // Randomised traffic: stray starts, random ready, occasional aborts.
    for (int c = 0; c < 2000; c++) begin
      start       = ($urandom_range(0, 5) == 0);
      num_ops     = CNT_W'($urandom_range(0, 7));
      issue_ready = ($urandom_range(0, 2) != 0);
      abort       = ($urandom_range(0, 39) == 0);
      step();
    end
    start = 1'b0; abort = 1'b0; issue_ready = 1'b1;
    for (int c = 0; c < 40; c++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
